// File: rtl/r2_sched_pkg.sv
// Shared types and default latencies for the r2 pair scheduler.
// Holds the sweep FSM state encoding and the default memory/r2 pipeline latencies.
package r2_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    localparam int DEF_R2_LATENCY = 17;
    localparam int DEF_RD_LATENCY = 1;

endpackage

// File: rtl/r2_tag_delay.sv
// Fixed-depth delay line carrying a valid bit and a payload word.
// Also reports whether any entry other than the output stage is still valid.
module r2_tag_delay #(
    parameter int DEPTH = 18,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             pending
);

    logic [DEPTH-1:0] valid_sr;
    logic [WIDTH-1:0] data_sr [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's old value; blocking here would collapse the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_sr <= '0;
        end else begin
            valid_sr[0] <= in_valid;
            for (int k = 1; k < DEPTH; k++) begin
                valid_sr[k] <= valid_sr[k-1];
            end
        end
    end

    // NOTE: the payload array is deliberately not reset; only the valid bits
    // matter, and the payload is qualified by them at the consumer.
    always_ff @(posedge clk) begin
        data_sr[0] <= in_data;
        for (int k = 1; k < DEPTH; k++) begin
            data_sr[k] <= data_sr[k-1];
        end
    end

    // NOTE: the accumulator gets its default before the loop, so this block
    // is purely combinational and infers no latch.
    always_comb begin
        pending = 1'b0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            pending = pending | valid_sr[k];
        end
    end

    assign out_valid = valid_sr[DEPTH-1];
    assign out_data  = data_sr[DEPTH-1];

endmodule

// File: rtl/r2_pair_scheduler.sv
// Cell-pair sweep scheduler: issues (i,j) particle reads and tags them through the r2 pipeline.
// Define R2_HALF_SHELL_EN to issue only j>i pairs when the two cells are the same cell.
module r2_pair_scheduler
    import r2_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int R2_LATENCY = DEF_R2_LATENCY,
    parameter int RD_LATENCY = DEF_RD_LATENCY
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   home_count,
    input  logic [ADDR_WIDTH-1:0]   nb_count,
    input  logic                    same_cell,
    input  logic                    stall,
    output logic [ADDR_WIDTH-1:0]   home_rd_addr,
    output logic [ADDR_WIDTH-1:0]   nb_rd_addr,
    output logic                    rd_en,
    output logic                    r2_enable,
    output logic                    tag_valid,
    output logic [ADDR_WIDTH-1:0]   tag_home_id,
    output logic [ADDR_WIDTH-1:0]   tag_nb_id,
    output logic [2*ADDR_WIDTH-1:0] pair_cnt,
    output logic                    busy,
    output logic                    done
);

    localparam int TAG_DEPTH = RD_LATENCY + R2_LATENCY;
    localparam int TAG_W     = 2 * ADDR_WIDTH;

    sched_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0]   home_q, nb_q;
    logic                    half_q;
    logic [ADDR_WIDTH-1:0]   i_q, j_q;
    logic [2*ADDR_WIDTH-1:0] pair_cnt_q;

    logic                    half_start;
    logic                    zero_pairs;
    logic [ADDR_WIDTH:0]     i_inc, j_inc;
    logic                    row_end, last_row_full, last_row_half, last_pair;
    logic [ADDR_WIDTH-1:0]   next_row_j;
    logic                    issue;

    logic                    tag_out_valid, tag_pending;
    logic [TAG_W-1:0]        tag_out_data;
    logic                    unused_en_data, unused_en_pending;

`ifdef R2_HALF_SHELL_EN
    assign half_start = same_cell;
`else
    logic unused_same_cell;
    assign unused_same_cell = same_cell;
    assign half_start       = 1'b0;
`endif

    // A half-shell sweep of a cell with fewer than two particles has no j>i pair.
    assign zero_pairs = (home_count == '0) || (nb_count == '0) ||
                        (half_start && ((home_count <= ADDR_WIDTH'(1)) ||
                                        (nb_count   <= ADDR_WIDTH'(1))));

    // One extra bit so i+1 / j+1 compare cleanly against a full-range count.
    assign i_inc         = {1'b0, i_q} + (ADDR_WIDTH+1)'(1);
    assign j_inc         = {1'b0, j_q} + (ADDR_WIDTH+1)'(1);
    assign row_end       = (j_inc == {1'b0, nb_q});
    assign last_row_full = (i_inc == {1'b0, home_q});
    assign last_row_half = (i_inc >= {1'b0, home_q}) ||
                           ((i_inc + (ADDR_WIDTH+1)'(1)) >= {1'b0, nb_q});
    assign last_pair     = row_end && (half_q ? last_row_half : last_row_full);
    assign next_row_j    = half_q ? (i_q + ADDR_WIDTH'(2)) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            home_q     <= '0;
            nb_q       <= '0;
            half_q     <= 1'b0;
            i_q        <= '0;
            j_q        <= '0;
            pair_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                home_q     <= home_count;
                nb_q       <= nb_count;
                half_q     <= half_start;
                i_q        <= '0;
                j_q        <= half_start ? ADDR_WIDTH'(1) : '0;
                pair_cnt_q <= '0;
            end else if (issue) begin
                pair_cnt_q <= pair_cnt_q + (2*ADDR_WIDTH)'(1);
                if (row_end) begin
                    i_q <= i_q + ADDR_WIDTH'(1);
                    j_q <= next_row_j;
                end else begin
                    j_q <= j_q + ADDR_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = zero_pairs ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    issue = 1'b1;
                    if (last_pair) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave once the final tag is at the output and nothing trails it.
                if (tag_out_valid && !tag_pending) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    r2_tag_delay #(
        .DEPTH (TAG_DEPTH),
        .WIDTH (TAG_W)
    ) u_tag_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue),
        .in_data   ({i_q, j_q}),
        .out_valid (tag_out_valid),
        .out_data  (tag_out_data),
        .pending   (tag_pending)
    );

    r2_tag_delay #(
        .DEPTH (RD_LATENCY),
        .WIDTH (1)
    ) u_en_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue),
        .in_data   (1'b0),
        .out_valid (r2_enable),
        .out_data  (unused_en_data),
        .pending   (unused_en_pending)
    );

    assign rd_en        = issue;
    assign home_rd_addr = i_q;
    assign nb_rd_addr   = j_q;
    assign pair_cnt     = pair_cnt_q;
    assign tag_valid    = tag_out_valid;
    assign tag_home_id  = tag_out_valid ? tag_out_data[TAG_W-1:ADDR_WIDTH] : '0;
    assign tag_nb_id    = tag_out_valid ? tag_out_data[ADDR_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_r2_pair_scheduler.sv
// Directed self-checking bench for r2_pair_scheduler with default latencies (tag latency 18).
// Half-shell vectors run only when R2_HALF_SHELL_EN is defined.
module tb_r2_pair_scheduler;

    localparam int TAG_LAT = 18;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  home_count, nb_count;
    logic        same_cell;
    logic        stall;
    logic [7:0]  home_rd_addr, nb_rd_addr;
    logic        rd_en, r2_enable, tag_valid;
    logic [7:0]  tag_home_id, tag_nb_id;
    logic [15:0] pair_cnt;
    logic        busy, done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    logic [15:0] iss_ij[$];
    int          iss_cyc[$];
    logic [15:0] tag_ij[$];
    int          tag_cyc[$];
    int          en_cyc[$];
    int          done_n;
    int          done_rel;
    int          busy_n;

    logic [15:0] exp_ij[$];
    int          exp_cyc[$];

    r2_pair_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .home_count   (home_count),
        .nb_count     (nb_count),
        .same_cell    (same_cell),
        .stall        (stall),
        .home_rd_addr (home_rd_addr),
        .nb_rd_addr   (nb_rd_addr),
        .rd_en        (rd_en),
        .r2_enable    (r2_enable),
        .tag_valid    (tag_valid),
        .tag_home_id  (tag_home_id),
        .tag_nb_id    (tag_nb_id),
        .pair_cnt     (pair_cnt),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rd_en === 1'b1) begin
            iss_ij.push_back({home_rd_addr, nb_rd_addr});
            iss_cyc.push_back(cyc - start_cyc);
        end
        if (r2_enable === 1'b1) en_cyc.push_back(cyc - start_cyc);
        if (tag_valid === 1'b1) begin
            tag_ij.push_back({tag_home_id, tag_nb_id});
            tag_cyc.push_back(cyc - start_cyc);
        end
        if (done === 1'b1) begin
            done_n   = done_n + 1;
            done_rel = cyc - start_cyc;
        end
        if (busy === 1'b1) busy_n = busy_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        iss_ij.delete();
        iss_cyc.delete();
        tag_ij.delete();
        tag_cyc.delete();
        en_cyc.delete();
        done_n   = 0;
        done_rel = -1;
        busy_n   = 0;
    endtask

    task automatic fill_cyc(input int n);
        exp_cyc.delete();
        for (int k = 1; k <= n; k++) exp_cyc.push_back(k);
    endtask

    task automatic do_start(input logic [7:0] h, input logic [7:0] n, input logic s);
        home_count = h;
        nb_count   = n;
        same_cell  = s;
        clear_mon();
        start      = 1'b1;
        start_cyc  = cyc;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            tick();
            if (done_n > 0) seen = 1'b1;
        end
        check({name, " done_seen"}, 32'(seen), 32'd1);
        repeat (4) tick();
    endtask

    task automatic check_sweep(input string name, input int exp_done_rel);
        int n;
        n = exp_ij.size();
        check({name, " issue_count"}, iss_ij.size(), n);
        check({name, " tag_count"}, tag_ij.size(), n);
        check({name, " r2en_count"}, en_cyc.size(), n);
        for (int k = 0; k < n; k++) begin
            if (k < iss_ij.size()) begin
                check($sformatf("%s issue_ij%0d", name, k), iss_ij[k], exp_ij[k]);
                check($sformatf("%s issue_cyc%0d", name, k), iss_cyc[k], exp_cyc[k]);
            end
            if (k < tag_ij.size()) begin
                check($sformatf("%s tag_ij%0d", name, k), tag_ij[k], exp_ij[k]);
                check($sformatf("%s tag_cyc%0d", name, k), tag_cyc[k], exp_cyc[k] + TAG_LAT);
            end
            if (k < en_cyc.size())
                check($sformatf("%s r2en_cyc%0d", name, k), en_cyc[k], exp_cyc[k] + 1);
        end
        check({name, " pair_cnt"}, pair_cnt, n);
        check({name, " done_pulses"}, done_n, 1);
        check({name, " done_cyc"}, done_rel, exp_done_rel);
        check({name, " busy_cycles"}, busy_n, exp_done_rel);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        home_count = '0;
        nb_count   = '0;
        same_cell  = 1'b0;
        stall      = 1'b0;
        clear_mon();
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset rd_en", rd_en, 0);
        check("reset r2_enable", r2_enable, 0);
        check("reset tag_valid", tag_valid, 0);
        check("reset pair_cnt", pair_cnt, 0);
        check("reset home_rd_addr", home_rd_addr, 0);
        check("reset nb_rd_addr", nb_rd_addr, 0);
        check("reset tag_ids", {tag_home_id, tag_nb_id}, 0);
        tick();

        // 2x3 full sweep: six back-to-back issues, last tag at 24, done at 25.
        do_start(8'd2, 8'd3, 1'b0);
        exp_ij = '{16'h0000, 16'h0001, 16'h0002, 16'h0100, 16'h0101, 16'h0102};
        fill_cyc(6);
        wait_done("basic");
        check_sweep("basic", 25);

        // Empty home cell: straight to DONE.
        do_start(8'd0, 8'd5, 1'b0);
        exp_ij.delete();
        fill_cyc(0);
        wait_done("empty");
        check_sweep("empty", 1);

        // 1x4 with stall on the 2nd issue cycle for three cycles.
        do_start(8'd1, 8'd4, 1'b0);
        tick();
        stall = 1'b1;
        repeat (3) tick();
        stall = 1'b0;
        exp_ij  = '{16'h0000, 16'h0001, 16'h0002, 16'h0003};
        exp_cyc = '{1, 5, 6, 7};
        wait_done("stall");
        check_sweep("stall", 26);

`ifdef R2_HALF_SHELL_EN
        do_start(8'd4, 8'd4, 1'b1);
        exp_ij = '{16'h0001, 16'h0002, 16'h0003, 16'h0102, 16'h0103, 16'h0203};
        fill_cyc(6);
        wait_done("half4");
        check_sweep("half4", 25);

        do_start(8'd1, 8'd1, 1'b1);
        exp_ij.delete();
        fill_cyc(0);
        wait_done("half1");
        check_sweep("half1", 1);
`else
        // same_cell has no effect without the half-shell build.
        do_start(8'd2, 8'd2, 1'b1);
        exp_ij = '{16'h0000, 16'h0001, 16'h0100, 16'h0101};
        fill_cyc(4);
        wait_done("same_full");
        check_sweep("same_full", 23);
`endif

        // Reset mid-ISSUE with five pairs in flight.
        do_start(8'd3, 8'd3, 1'b0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst busy", busy, 0);
        check("midrst rd_en", rd_en, 0);
        check("midrst pair_cnt", pair_cnt, 0);
        check("midrst tag_valid", tag_valid, 0);
        clear_mon();
        repeat (30) tick();
        check("midrst tags_after", tag_ij.size(), 0);
        check("midrst done_after", done_n, 0);

        do_start(8'd2, 8'd3, 1'b0);
        exp_ij = '{16'h0000, 16'h0001, 16'h0002, 16'h0100, 16'h0101, 16'h0102};
        fill_cyc(6);
        wait_done("after_rst");
        check_sweep("after_rst", 25);

        // start pulsed during DRAIN is ignored.
        do_start(8'd2, 8'd3, 1'b0);
        repeat (9) tick();
        home_count = 8'd1;
        nb_count   = 8'd1;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        wait_done("drain_start");
        check_sweep("drain_start", 25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
